// File: rtl/fram_wb_writer.sv
// fram_wb_writer: writeback stage feeding the feature-RAM router write port.
//
// Accepts PE result words over a valid/ready handshake, buffers {address, data}
// pairs in a DEPTH-entry FIFO (address = base_addr + word index, wrapping at the
// FRAM address width) and issues at most one registered write per cycle.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_start                   job start pulse (IDLE only); latches i_base_addr/i_length
//   i_base_addr, i_length     first write address and word count of the job
//   i_in_valid/o_in_ready     input handshake, i_in_data is the result word
//   i_rp_addr, i_rp_active    router read-port activity (bank-conflict stall only)
//   o_wp_addr/o_wp_wdata/o_wp_en  registered write port to the router
//   o_busy                    high while a job is running
//   o_done                    one-cycle pulse at job completion
//
// Optional feature: define FRAM_WB_CONFLICT_STALL_EN to hold the FIFO head while
// the read port is active in the same bank (top $clog2(`FRAM_BANK_NUM) address
// bits). Without it, rp_* are ignored and the router arbitrates in favour of writes.

`ifndef FRAM_ADDR_WIDTH
`define FRAM_ADDR_WIDTH 8
`endif
`ifndef FRAM_ADDR_RANGE
`define FRAM_ADDR_RANGE `FRAM_ADDR_WIDTH-1:0
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef DATA_RANGE
`define DATA_RANGE `DATA_WIDTH-1:0
`endif
`ifndef FRAM_BANK_NUM
`define FRAM_BANK_NUM 4
`endif

module fram_wb_writer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [`FRAM_ADDR_RANGE] i_base_addr,
  input  logic [15:0]             i_length,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [`DATA_RANGE]      i_in_data,
  input  logic [`FRAM_ADDR_RANGE] i_rp_addr,
  input  logic                    i_rp_active,
  output logic [`FRAM_ADDR_RANGE] o_wp_addr,
  output logic [`DATA_RANGE]      o_wp_wdata,
  output logic                    o_wp_en,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned AW = `FRAM_ADDR_WIDTH;
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned EW = AW + DW;
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          r_state;
  logic [AW-1:0]   r_base;
  logic [15:0]     r_len;
  logic [15:0]     r_acc_cnt;
  logic [15:0]     r_wr_cnt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;
  logic [AW-1:0]   r_wp_addr;
  logic [DW-1:0]   r_wp_wdata;
  logic            r_wp_en;
  logic            r_done;

  logic            w_full;
  logic            w_empty;
  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_stall;
  logic            w_last_wr;
  logic [EW-1:0]   w_head;
  logic [AW-1:0]   w_push_addr;

  assign w_full      = (r_count == (PW+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  // Push is gated by the pre-pop full flag, so a full FIFO never accepts even
  // when it is draining in the same cycle.
  assign w_in_ready  = (r_state == StRun) && !w_full && (r_acc_cnt < r_len);
  assign w_push      = i_in_valid && w_in_ready;
  assign w_head      = r_mem[r_rptr];
  assign w_pop       = !w_empty && !w_stall;
  assign w_push_addr = r_base + r_acc_cnt[AW-1:0];
  assign w_last_wr   = r_wp_en && (r_wr_cnt == r_len - 16'd1);

`ifdef FRAM_WB_CONFLICT_STALL_EN
  localparam int unsigned BB = $clog2(`FRAM_BANK_NUM);
  assign w_stall = i_rp_active && (w_head[EW-1 -: BB] == i_rp_addr[AW-1 -: BB]);
`else
  logic w_unused_rp;
  assign w_stall     = 1'b0;
  assign w_unused_rp = ^{i_rp_addr, i_rp_active};
`endif

  // Storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_push_addr, i_in_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_base     <= '0;
      r_len      <= '0;
      r_acc_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wp_addr  <= '0;
      r_wp_wdata <= '0;
      r_wp_en    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_wp_en <= w_pop;

      if (w_push) begin
        r_wptr    <= r_wptr + 1'b1;
        r_acc_cnt <= r_acc_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + 1'b1;
        r_wp_addr  <= w_head[EW-1:DW];
        r_wp_wdata <= w_head[DW-1:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_wp_en) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_base    <= i_base_addr;
            r_len     <= i_length;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
            // An empty job completes immediately without entering RUN.
            if (i_length == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          // Done is raised the cycle after the final write; the job leaves RUN
          // at the end of that done cycle so busy covers it.
          if (r_done) begin
            r_state <= StIdle;
          end else if (w_last_wr) begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_wp_addr  = r_wp_addr;
  assign o_wp_wdata = r_wp_wdata;
  assign o_wp_en    = r_wp_en;
  assign o_busy     = (r_state == StRun);
  assign o_done     = r_done;

endmodule

// File: tb/tb_fram_wb_writer.sv
`ifndef FRAM_ADDR_WIDTH
`define FRAM_ADDR_WIDTH 8
`endif
`ifndef FRAM_ADDR_RANGE
`define FRAM_ADDR_RANGE `FRAM_ADDR_WIDTH-1:0
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef DATA_RANGE
`define DATA_RANGE `DATA_WIDTH-1:0
`endif
`ifndef FRAM_BANK_NUM
`define FRAM_BANK_NUM 4
`endif

module tb_fram_wb_writer;
  localparam int AW = `FRAM_ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [15:0]   i_length;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DW-1:0] i_in_data;
  logic [AW-1:0] i_rp_addr;
  logic          i_rp_active;
  logic [AW-1:0] o_wp_addr;
  logic [DW-1:0] o_wp_wdata;
  logic          o_wp_en;
  logic          o_busy;
  logic          o_done;

  fram_wb_writer #(.DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_length    (i_length),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_rp_addr   (i_rp_addr),
    .i_rp_active (i_rp_active),
    .o_wp_addr   (o_wp_addr),
    .o_wp_wdata  (o_wp_wdata),
    .o_wp_en     (o_wp_en),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected {addr, data} pushed at job start, popped per write.
  logic [AW+DW-1:0] exp_q[$];
  int wr_cycs[$];
  int wr_total = 0;

  int            job_len;
  int            job_wr0;
  int            acc_idx;
  int            first_acc_cyc;
  logic [DW-1:0] job_seed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (o_wp_en) begin
      wr_total++;
      wr_cycs.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                 o_wp_addr, o_wp_wdata);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({o_wp_addr, o_wp_wdata} !== e) begin
          failures++;
          $display("FAIL wp_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   o_wp_addr, o_wp_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (!rst_n) exp_q.delete();
  end

  task automatic start_job(input logic [AW-1:0] base, input int len, input logic [DW-1:0] seed);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    job_len  = len;
    job_seed = seed;
    acc_idx  = 0;
    job_wr0  = wr_total;
    for (int k = 0; k < len; k++) begin
      a = base + AW'(k);
      d = seed + DW'(k);
      exp_q.push_back({a, d});
    end
    i_start = 1'b1; i_base_addr = base; i_length = 16'(len);
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, {31'd0, len != 0});
  endtask

  task automatic feed(input int max_cycles);
    for (int c = 0; c < max_cycles && acc_idx < job_len; c++) begin
      i_in_valid = 1'b1;
      i_in_data  = job_seed + DW'(acc_idx);
      @(negedge clk);
      if (o_in_ready) begin
        if (acc_idx == 0) first_acc_cyc = cyc;
        acc_idx++;
      end
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit found = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (o_done) begin found = 1; break; end
    end
    chk("done_seen", {31'd0, found}, 32'd1);
    if (found) begin
      chk("busy_in_done_cycle", {31'd0, o_busy}, 32'd1);
      if (wr_cycs.size() > 0) chk("done_after_last_write", cyc, wr_cycs[wr_cycs.size()-1] + 1);
    end
    chk("write_count", wr_total - job_wr0, job_len);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single_pulse", {31'd0, o_done}, 32'd0);
    chk("busy_dropped", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd0);
    chk({tag, "_wp_addr"}, 32'(o_wp_addr), 32'd0);
    chk({tag, "_wp_wdata"}, 32'(o_wp_wdata), 32'd0);
    chk({tag, "_wp_en"}, {31'd0, o_wp_en}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_length = '0;
    i_in_valid = 1'b0; i_in_data = '0; i_rp_addr = '0; i_rp_active = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;

    // Basic job: 4 words back-to-back at 0x10.
    start_job(8'h10, 4, 16'hA000);
    feed(20);
    wait_done(20);
    chk("latency_accept_to_write", wr_cycs[job_wr0] - first_acc_cyc, 2);
    chk("writes_consecutive", wr_cycs[job_wr0 + 3] - wr_cycs[job_wr0], 3);

    // in_valid while IDLE is never accepted.
    i_in_valid = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, o_in_ready}, 32'd0);
    @(posedge clk); #1;
    i_in_valid = 1'b0;

    // Backpressure: same-bank read active (0x40 and 0x50 share the top bank bits).
    i_rp_addr = 8'h50; i_rp_active = 1'b1;
    start_job(8'h40, 8, 16'hB100);
    feed(10);
`ifdef FRAM_WB_CONFLICT_STALL_EN
    chk("stall_accepts", acc_idx, 4);
    chk("stall_no_writes", wr_total - job_wr0, 0);
    chk("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
    i_rp_active = 1'b0;
    feed(40);
`else
    chk("nostall_accepts", acc_idx, 8);
    chk("nostall_throughput", first_acc_cyc + 7 - cyc + 1, 0);
`endif
    i_rp_active = 1'b0;
    wait_done(30);

    // Wrap-around at top of address space.
    start_job(8'hFE, 3, 16'hC200);
    feed(20);
    wait_done(20);

    // Read active in a different bank (macro on) / same bank (macro off): no stall.
`ifdef FRAM_WB_CONFLICT_STALL_EN
    i_rp_addr = 8'hC0;
`else
    i_rp_addr = 8'h30;
`endif
    i_rp_active = 1'b1;
    start_job(8'h30, 2, 16'hD300);
    feed(20);
    wait_done(20);
    chk("rp_active_latency", wr_cycs[job_wr0] - first_acc_cyc, 2);
    i_rp_active = 1'b0;

    // Zero-length job.
    start_job(8'h55, 0, 16'hE400);
    @(negedge clk);
    chk("len0_done", {31'd0, o_done}, 32'd1);
    chk("len0_busy", {31'd0, o_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("len0_done_cleared", {31'd0, o_done}, 32'd0);
    chk("len0_no_writes", wr_total - job_wr0, 0);
    @(posedge clk); #1;

    // Reset mid-job after 2 of 5 writes.
    start_job(8'h80, 5, 16'hF500);
    feed(2);
    for (int c = 0; c < 20; c++) begin
      if (wr_total - job_wr0 >= 2) break;
      @(posedge clk); #1;
    end
    chk("writes_before_reset", wr_total - job_wr0, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midjob_reset");
    @(posedge clk); #1;

    // Fresh job after reset starts from index 0.
    start_job(8'h20, 3, 16'h1600);
    feed(20);
    wait_done(20);
    chk("post_reset_latency", wr_cycs[job_wr0] - first_acc_cyc, 2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
